// File: rtl/ifetch.sv
`timescale 1ns/1ps
// ifetch: fetch stage between PC and decode, one outstanding imem request at a time.
// Define IFETCH_RVC_EN for 16-bit (compressed) support; the default build is 32-bit only.
module ifetch #(
  parameter int XLEN   = 32,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [XLEN-1:0]   pc_value,
  input  logic              redirect,
  output logic [STEP_W-1:0] step_size,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_is_c,
  output logic              fetch_misaligned
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT,
`ifdef IFETCH_RVC_EN
    S_REQ_HI, S_WAIT_HI,
`endif
    S_HOLD
  } state_t;

  state_t          r_state, w_next;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_is_c;
  logic [1:0]      r_drop;   // stale responses still to be discarded
  logic            r_mis;
  logic            w_pc_bad, w_mis_pulse, w_rv_live, w_waiting, w_live_pend;
  logic            w_hs, w_drop_dec, w_drop_inc;

`ifdef IFETCH_RVC_EN
  logic [15:0] r_lo, w_half;
  assign w_pc_bad  = pc_value[0];
  assign w_half    = r_inst_pc[1] ? imem_rdata[31:16] : imem_rdata[15:0];
  assign w_waiting = (r_state == S_WAIT) || (r_state == S_WAIT_HI);
`else
  assign w_pc_bad  = |pc_value[1:0];
  assign w_waiting = (r_state == S_WAIT);
`endif

  assign w_mis_pulse = (r_state == S_REQ) && w_pc_bad && !r_mis;
  assign w_rv_live   = imem_rvalid && (r_drop == 2'd0);
  assign w_hs        = (r_state == S_HOLD) && inst_ready;

  // A live request is still in flight after this edge: its response must be dropped on redirect.
  assign w_live_pend = (w_waiting && !w_rv_live) || (imem_req && imem_gnt);
  assign w_drop_dec  = imem_rvalid && (r_drop != 2'd0);
  assign w_drop_inc  = redirect && w_live_pend;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    case (r_state)
      // Saturated drop count blocks new requests so the counter cannot overflow.
      S_REQ: if (!w_pc_bad && (r_drop != 2'd3)) begin
        imem_req  = 1'b1;
        imem_addr = {pc_value[XLEN-1:2], 2'b00};
      end
`ifdef IFETCH_RVC_EN
      S_REQ_HI: begin
        imem_req  = 1'b1;
        imem_addr = {r_inst_pc[XLEN-1:2], 2'b00} + XLEN'(4);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ:  if (imem_req && imem_gnt) w_next = S_WAIT;
      S_WAIT: if (w_rv_live) begin
`ifdef IFETCH_RVC_EN
        if ((w_half[1:0] == 2'b11) && r_inst_pc[1]) w_next = S_REQ_HI;
        else                                        w_next = S_HOLD;
`else
        w_next = S_HOLD;
`endif
      end
`ifdef IFETCH_RVC_EN
      S_REQ_HI:  if (imem_req && imem_gnt) w_next = S_WAIT_HI;
      S_WAIT_HI: if (w_rv_live) w_next = S_HOLD;
`endif
      S_HOLD: if (inst_ready) w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
    if (redirect) w_next = S_REQ;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_is_c    <= 1'b0;
      r_drop    <= 2'd0;
      r_mis     <= 1'b0;
`ifdef IFETCH_RVC_EN
      r_lo      <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_drop  <= r_drop - {1'b0, w_drop_dec} + {1'b0, w_drop_inc};
      if (redirect)         r_mis <= 1'b0;
      else if (w_mis_pulse) r_mis <= 1'b1;
      if (r_state == S_REQ) r_inst_pc <= pc_value;
      if ((r_state == S_WAIT) && w_rv_live) begin
`ifdef IFETCH_RVC_EN
        if (w_half[1:0] != 2'b11) begin
          r_inst <= {16'h0000, w_half};
          r_is_c <= 1'b1;
        end else begin
          r_inst <= imem_rdata;
          r_is_c <= 1'b0;
          r_lo   <= w_half;
        end
`else
        r_inst <= imem_rdata;
        r_is_c <= 1'b0;
`endif
      end
`ifdef IFETCH_RVC_EN
      if ((r_state == S_WAIT_HI) && w_rv_live) r_inst <= {imem_rdata[15:0], r_lo};
`endif
    end
  end

  assign inst_valid       = (r_state == S_HOLD);
  assign inst             = r_inst;
  assign inst_pc          = r_inst_pc;
  assign inst_is_c        = r_is_c;
  assign fetch_misaligned = w_mis_pulse;
  assign step_size        = w_hs ? (r_is_c ? STEP_W'(2) : STEP_W'(4)) : '0;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage that sits between the program counter and decode. It consumes the current `pc_value` and issues word-aligned requests to instruction memory, one at a time. It extracts the 16- or 32-bit instruction at that PC and hands it to decode over a valid/ready handshake. It drives the PC's `step_size` input: nonzero only in the cycle an instruction is accepted by decode, so the PC advances exactly once per delivered instruction.

## Interface
Parameters:
- `STEP_W`, default 8: width of `step_size`; must match the PC's step input.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `pc_value`  in  `XLEN`  current PC from the PC stage.
- `redirect`  in  1  same strobe as PC `set_pc`; flushes fetch.
- `step_size`  out  `STEP_W`  PC increment: 0, 2 or 4.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  `XLEN`  word address, bits [1:0] always 0.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data, little-endian.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts.
- `inst`  out  32  instruction; a 16-bit instruction is zero-extended.
- `inst_pc`  out  `XLEN`  PC of `inst`.
- `inst_is_c`  out  1  `inst` is a 16-bit encoding.
- `fetch_misaligned`  out  1  one-cycle pulse on an illegal PC alignment.

## Operation
- FSM states: IDLE, REQ, WAIT, REQ_HI, WAIT_HI, HOLD.
- Reset: state IDLE. All outputs 0.
- IDLE -> REQ unconditionally on the next edge.
- REQ: `imem_req`=1, `imem_addr`={pc_value[XLEN-1:2],2'b00}. Latch `pc_value` into `inst_pc`. On `imem_gnt`, go to WAIT.
- WAIT: on `imem_rvalid`, select the halfword pointed to by `inst_pc[1]`.
  - If bits [1:0] != 2'b11: 16-bit instruction, go to HOLD.
  - If pc[1]=0 and bits [1:0] == 2'b11: full word, go to HOLD.
  - If pc[1]=1 and bits [1:0] == 2'b11: save the upper halfword as the instruction's low half, go to REQ_HI.
- REQ_HI: request word address+4. On `imem_gnt`, go to WAIT_HI.
- WAIT_HI: on `imem_rvalid`, `inst`={rdata[15:0], saved half}, go to HOLD.
- HOLD: `inst_valid`=1. Outputs stay stable until accepted.
  - On `inst_valid && inst_ready`, `step_size` is 2 if `inst_is_c`, else 4, combinationally in that cycle. Next state is REQ.
- `step_size` is 0 in every cycle without a handshake.
- At most one outstanding memory request.
- `redirect` in any state:
  - Next state is REQ. `inst_valid` drops next cycle.
  - An outstanding response is discarded via a drop flag: the first `imem_rvalid` after the flag is set is ignored and clears the flag.
  - REQ may be entered with the drop flag set. The new request may be granted before the stale response returns; the stale response is still dropped first.
- `redirect` coincident with a handoff: `redirect` wins. The PC takes `set_pc_value`, and the handoff still counts as delivered to decode.
- Address arithmetic wraps modulo 2^`XLEN` (fetch at the top word with pc[1]=1 wraps to address 0).

## Timing
- Reset exit: first `imem_req` in the 2nd cycle after `rstn` rises.
- Zero-wait memory (gnt in REQ, rvalid the next cycle): REQ, WAIT, HOLD gives 3 cycles per instruction. A spanning instruction takes 5.
- `inst`, `inst_pc` and `inst_is_c` are registered. `step_size` is combinational from state and `inst_ready`.
- `imem_addr` is held stable while `imem_req`=1 and `imem_gnt`=0.

## Configuration
- `IFETCH_RVC_EN` defined:
  - Compressed decode as above.
  - pc[1]=1 is legal.
  - `fetch_misaligned` pulses only for pc[0]=1; the FSM then holds in REQ without requesting until `redirect`.
- `IFETCH_RVC_EN` undefined:
  - Every instruction is 32 bits: `inst_is_c`=0, `step_size` is 4 on handoff.
  - REQ_HI and WAIT_HI are removed.
  - pc[1:0]!=0 pulses `fetch_misaligned` and holds, as above.

## Test plan
- Reset, zero-wait memory returning 0x00000013 at address 0 -> `imem_req` in cycle 2; `inst`=0x00000013, `inst_pc`=0 on `inst_valid`; `step_size`=4 in the handshake cycle only.
- `inst_ready` held low for 5 cycles in HOLD -> `inst` stable; `step_size`=0 throughout; no new `imem_req`.
- With `IFETCH_RVC_EN`, word 0 = 0x00B50001 -> first `inst`=0x00000001, `inst_is_c`=1, `step_size`=2. Then PC=2 with halfword 0x00B5 (ends in 2'b01, 16-bit) -> `inst`=0x000000B5, `inst_is_c`=1, `step_size`=2.
- With `IFETCH_RVC_EN`, PC=0x6, word 0x4 = 0x0513xxxx, word 0x8 = 0x....0000 -> two requests (0x4, 0x8); `inst`=0x00000513, `step_size`=4.
- `redirect` while WAIT with a delayed `imem_rvalid` -> stale data never appears on `inst`; the next request uses the new `pc_value`.
- Without `IFETCH_RVC_EN`, PC=0x2 -> `fetch_misaligned` pulses once; `imem_req`=0 until `redirect`.
